// File: rtl/tracer_udma_packer_if.sv
// ============================================================================
// Module  : tracer_udma_packer_if
// Brief   : Trace-beat and uDMA RX handshake bundle for tracer_udma_packer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface tracer_udma_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 4
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int FILL_W    = $clog2(DEPTH) + 1;

    logic                 en_i;
    logic                 clr_i;
    logic                 flush_i;
    logic [IN_WIDTH-1:0]  trace_data_i;
    logic                 trace_valid_i;
    logic                 trace_ready_o;
    logic [1:0]           data_rx_datasize_o;
    logic [OUT_WIDTH-1:0] data_rx_data_o;
    logic                 data_rx_valid_o;
    logic                 data_rx_ready_i;
    logic [FILL_W-1:0]    fill_o;
    logic                 pack_empty_o;
    logic [15:0]          drop_cnt_o;

    modport slave (
        input  en_i, clr_i, flush_i, trace_data_i, trace_valid_i, data_rx_ready_i,
        output trace_ready_o, data_rx_datasize_o, data_rx_data_o, data_rx_valid_o,
               fill_o, pack_empty_o, drop_cnt_o
    );

    modport master (
        output en_i, clr_i, flush_i, trace_data_i, trace_valid_i, data_rx_ready_i,
        input  trace_ready_o, data_rx_datasize_o, data_rx_data_o, data_rx_valid_o,
               fill_o, pack_empty_o, drop_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/tracer_udma_packer.sv
// ============================================================================
// Module  : tracer_udma_packer
// Brief   : Packs RATIO trace beats into one uDMA word and queues words in a
//           FWFT FIFO. Optional macro TRACER_UDMA_PACKER_DROP_EN selects
//           drop-on-full instead of back-pressure.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tracer_udma_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 4
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    tracer_udma_packer_if.slave  bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int FILL_W    = PTR_W + 1;

    logic [LANE_W-1:0]    lane;
    logic [OUT_WIDTH-1:0] pack;
    logic [OUT_WIDTH-1:0] pack_next;
    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [FILL_W-1:0]    fill;

    logic valid, pop, space, last_lane, ready, accept, complete, flush_push, push;
    logic [OUT_WIDTH-1:0] push_word;

    always_comb begin
        pack_next = pack;
        pack_next[int'(lane)*IN_WIDTH +: IN_WIDTH] = bus.trace_data_i;
    end

    assign valid      = (fill != '0);
    assign pop        = valid && bus.data_rx_ready_i;
    assign space      = (fill < FILL_W'(DEPTH)) || pop;
    assign last_lane  = (lane == LANE_W'(RATIO - 1));

`ifdef TRACER_UDMA_PACKER_DROP_EN
    assign ready      = !rst_i && bus.en_i && !bus.flush_i && !bus.clr_i;
`else
    assign ready      = !rst_i && bus.en_i && !bus.flush_i && !bus.clr_i
                        && (!last_lane || space);
`endif

    assign accept     = bus.trace_valid_i && ready;
    assign complete   = accept && last_lane;
    // Flush is blocked from coinciding with beats because it deasserts ready.
    assign flush_push = !rst_i && bus.flush_i && !bus.clr_i && (lane != '0) && space;
    assign push_word  = complete ? pack_next : pack;

`ifdef TRACER_UDMA_PACKER_DROP_EN
    logic        drop;
    logic [15:0] drop_cnt;

    assign push = (complete && space) || flush_push;
    assign drop = complete && !space;

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clr_i) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign bus.drop_cnt_o = drop_cnt;
`else
    assign push = complete || flush_push;
    assign bus.drop_cnt_o = '0;
`endif

    // Storage needs no reset: push is never asserted during reset or clear.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clr_i) begin
            lane   <= '0;
            pack   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (accept) begin
                if (last_lane) begin
                    lane <= '0;
                    pack <= '0;
                end else begin
                    lane <= lane + LANE_W'(1);
                    pack <= pack_next;
                end
            end else if (flush_push) begin
                lane <= '0;
                pack <= '0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (push && !pop) begin
                fill <= fill + FILL_W'(1);
            end else if (pop && !push) begin
                fill <= fill - FILL_W'(1);
            end
        end
    end

    assign bus.trace_ready_o      = ready;
    assign bus.data_rx_valid_o    = valid;
    assign bus.data_rx_data_o     = valid ? mem[rd_ptr] : '0;
    assign bus.fill_o             = fill;
    assign bus.pack_empty_o       = (lane == '0);
    assign bus.data_rx_datasize_o = (OUT_WIDTH == 8)  ? 2'd0 :
                                    (OUT_WIDTH == 16) ? 2'd1 : 2'd2;

endmodule

`default_nettype wire

// File: tb/tb_tracer_udma_packer.sv
// ============================================================================
// Module  : tb_tracer_udma_packer
// Brief   : Directed scoreboard bench for tracer_udma_packer (8x2 and 8x4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tracer_udma_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tracer_udma_packer_if #(.IN_WIDTH(8), .RATIO(2), .DEPTH(4)) b1 ();
    tracer_udma_packer_if #(.IN_WIDTH(8), .RATIO(4), .DEPTH(4)) b2 ();

    tracer_udma_packer #(.IN_WIDTH(8), .RATIO(2), .DEPTH(4)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b1.slave)
    );

    tracer_udma_packer #(.IN_WIDTH(8), .RATIO(4), .DEPTH(4)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b2.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp1 [$];
    logic [31:0] exp2 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Scoreboard monitors: a word is consumed whenever valid && ready at the sample point.
    always @(negedge clk) begin
        if (!rst && b1.data_rx_valid_o && b1.data_rx_ready_i) begin
            if (exp1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m1_unexpected: got 0x%0h expected no word", b1.data_rx_data_o);
            end else begin
                check("m1_word", 32'(b1.data_rx_data_o), exp1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b2.data_rx_valid_o && b2.data_rx_ready_i) begin
            if (exp2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m2_unexpected: got 0x%0h expected no word", b2.data_rx_data_o);
            end else begin
                check("m2_word", 32'(b2.data_rx_data_o), exp2.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] beats [4];
        logic       vexp  [4];
        beats = '{8'h11, 8'h22, 8'h33, 8'h44};
        vexp  = '{1'b0, 1'b0, 1'b1, 1'b0};

        {b1.en_i, b1.clr_i, b1.flush_i, b1.trace_valid_i, b1.data_rx_ready_i} = '0;
        {b2.en_i, b2.clr_i, b2.flush_i, b2.trace_valid_i, b2.data_rx_ready_i} = '0;
        b1.trace_data_i = '0;
        b2.trace_data_i = '0;

        // Reset: en held high to show reset forces trace_ready low
        b1.en_i = 1'b1;
        b1.trace_valid_i = 1'b1;
        repeat (3) tick();
        at_neg();
        check("rst_ready",     32'(b1.trace_ready_o),   32'd0);
        check("rst_valid",     32'(b1.data_rx_valid_o), 32'd0);
        check("rst_data",      32'(b1.data_rx_data_o),  32'd0);
        check("rst_fill",      32'(b1.fill_o),          32'd0);
        check("rst_pack_empty",32'(b1.pack_empty_o),    32'd1);
        check("rst_drop",      32'(b1.drop_cnt_o),      32'd0);
        check("datasize16",    32'(b1.data_rx_datasize_o), 32'd1);
        tick();
        rst = 1'b0;
        b1.trace_valid_i = 1'b0;

        // Streaming with ready high
        b1.data_rx_ready_i = 1'b1;
        exp1.push_back(32'h2211);
        exp1.push_back(32'h4433);
        b1.trace_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b1.trace_data_i = beats[i];
            at_neg();
            check("t1_valid_lat", 32'(b1.data_rx_valid_o), 32'(vexp[i]));
            check("t1_fill_le1",  32'(b1.fill_o <= 3'd1), 32'd1);
            tick();
        end
        b1.trace_valid_i = 1'b0;
        at_neg();
        check("t1_valid_last", 32'(b1.data_rx_valid_o), 32'd1);
        tick();
        at_neg();
        check("t1_drained", 32'(b1.data_rx_valid_o), 32'd0);

`ifdef TRACER_UDMA_PACKER_DROP_EN
        // Drop mode: full FIFO discards completing words
        b1.data_rx_ready_i = 1'b0;
        b1.trace_valid_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            b1.trace_data_i = 8'(i);
            if (i % 2 == 0) exp1.push_back({16'h0, 8'(i), 8'(i - 1)});
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            b1.trace_data_i = 8'h80 + 8'(i);
            at_neg();
            check("drop_ready", 32'(b1.trace_ready_o), 32'd1);
            tick();
        end
        b1.trace_valid_i = 1'b0;
        at_neg();
        check("drop_cnt",  32'(b1.drop_cnt_o), 32'd3);
        check("drop_fill", 32'(b1.fill_o),     32'd4);
        tick();
        b1.data_rx_ready_i = 1'b1;
        repeat (4) tick();
        at_neg();
        check("drop_drained", 32'(b1.fill_o), 32'd0);
        tick();
`else
        // Back-pressure: 10 beats against a stalled sink
        b1.data_rx_ready_i = 1'b0;
        b1.trace_valid_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            b1.trace_data_i = 8'(i);
            if (i % 2 == 0) exp1.push_back({16'h0, 8'(i), 8'(i - 1)});
            tick();
        end
        b1.trace_data_i = 8'h0A;
        at_neg();
        check("bp_ready_low", 32'(b1.trace_ready_o), 32'd0);
        check("bp_fill_full", 32'(b1.fill_o),        32'd4);
        tick();
        at_neg();
        check("bp_ready_hold", 32'(b1.trace_ready_o), 32'd0);
        check("bp_pack_held",  32'(b1.pack_empty_o),  32'd0);
        tick();
        b1.data_rx_ready_i = 1'b1;
        exp1.push_back(32'h0A09);
        at_neg();
        check("bp_ready_pop", 32'(b1.trace_ready_o), 32'd1);
        tick();
        b1.data_rx_ready_i = 1'b0;
        b1.trace_valid_i = 1'b0;
        at_neg();
        check("bp_fill_same", 32'(b1.fill_o),       32'd4);
        check("bp_pack_empty",32'(b1.pack_empty_o), 32'd1);
        tick();
        b1.data_rx_ready_i = 1'b1;
        repeat (4) tick();
        at_neg();
        check("bp_drained", 32'(b1.fill_o), 32'd0);
        tick();
`endif

        // Flush of a partial word, then flush with empty packer
        b1.data_rx_ready_i = 1'b1;
        b1.trace_valid_i = 1'b1;
        b1.trace_data_i = 8'hAB;
        tick();
        b1.trace_valid_i = 1'b0;
        b1.flush_i = 1'b1;
        exp1.push_back(32'h00AB);
        at_neg();
        check("fl_pack_partial", 32'(b1.pack_empty_o),  32'd0);
        check("fl_ready_low",    32'(b1.trace_ready_o), 32'd0);
        tick();
        at_neg();
        check("fl_pack_empty", 32'(b1.pack_empty_o),    32'd1);
        check("fl_valid",      32'(b1.data_rx_valid_o), 32'd1);
        tick();
        at_neg();
        check("fl_empty_nopush", 32'(b1.data_rx_valid_o), 32'd0);
        tick();
        b1.flush_i = 1'b0;
        at_neg();
        check("fl_fill", 32'(b1.fill_o), 32'd0);

        // en low: beats refused, nothing retained
        tick();
        b1.en_i = 1'b0;
        b1.trace_valid_i = 1'b1;
        b1.trace_data_i = 8'h99;
        at_neg();
        check("en_low_ready", 32'(b1.trace_ready_o), 32'd0);
        tick();
        b1.trace_valid_i = 1'b0;
        b1.en_i = 1'b1;
        at_neg();
        check("en_low_pack", 32'(b1.pack_empty_o), 32'd1);

        // Clear with full FIFO, partial lane and a beat offered
        tick();
        b1.data_rx_ready_i = 1'b0;
        b1.trace_valid_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            b1.trace_data_i = 8'h20 + 8'(i);
            tick();
        end
        b1.trace_data_i = 8'h55;
        b1.clr_i = 1'b1;
        at_neg();
        check("clr_fill_before", 32'(b1.fill_o),        32'd4);
        check("clr_ready",       32'(b1.trace_ready_o), 32'd0);
        tick();
        b1.clr_i = 1'b0;
        b1.trace_valid_i = 1'b0;
        at_neg();
        check("clr_fill",       32'(b1.fill_o),          32'd0);
        check("clr_valid",      32'(b1.data_rx_valid_o), 32'd0);
        check("clr_pack_empty", 32'(b1.pack_empty_o),    32'd1);
        check("clr_drop",       32'(b1.drop_cnt_o),      32'd0);
        tick();
        b1.data_rx_ready_i = 1'b1;
        b1.trace_valid_i = 1'b1;
        exp1.push_back(32'h7766);
        b1.trace_data_i = 8'h66;
        tick();
        b1.trace_data_i = 8'h77;
        tick();
        b1.trace_valid_i = 1'b0;
        repeat (2) tick();

        // Wide packing: 4 beats of 8 bits into one 32-bit word
        b2.en_i = 1'b1;
        b2.data_rx_ready_i = 1'b1;
        b2.trace_valid_i = 1'b1;
        exp2.push_back(32'h04030201);
        for (int i = 1; i <= 4; i++) begin
            b2.trace_data_i = 8'(i);
            tick();
        end
        b2.trace_valid_i = 1'b0;
        at_neg();
        check("w_datasize", 32'(b2.data_rx_datasize_o), 32'd2);
        check("w_valid",    32'(b2.data_rx_valid_o),    32'd1);
        repeat (2) tick();

        at_neg();
        check("sb1_empty", 32'(exp1.size()), 32'd0);
        check("sb2_empty", 32'(exp2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
